dither_gen_lfsr: RTL and testbench
==================================

Name: dither_gen_lfsr

Overview:
Parametrised pseudo-random dither source for the DAC digital path; successor to the fixed 6-input binary dither generator. A configurable-length Fibonacci LFSR with run-time seed load and zero-state protection drives one of four output modes: off, binary ±1, uniform (RPDF) or triangular (TPDF). The output is registered, scalable by arithmetic shift and qualified by a valid strobe, so it can be added ahead of the noise shaper / modulator at the oversampled rate.

Parameters:
LFSR_W, 24, LFSR length in bits; legal range 4..32; must satisfy LFSR_W >= 2*(OUT_W-1).
TAPS, 24'hE10000, feedback mask; bit i set means state[i] enters the XOR feedback. Default is x^24+x^23+x^22+x^17+1.
SEED, 24'h000001, non-zero reset and fallback seed, LFSR_W bits.
OUT_W, 4, dither output width, two's complement; legal range >= 2.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous and active-high
clk_en  in  1  sample-rate enable; LFSR advances and output updates only when it is high
mode  in  2  00 off, 01 binary ±1, 10 RPDF, 11 TPDF
amp  in  3  attenuation; output is arithmetically right-shifted by amp; values >= OUT_W are clamped to OUT_W-1
seed_load  in  1  load the seed input into the LFSR
seed  in  LFSR_W  run-time seed value
dither  out  OUT_W  signed dither sample (registered)
dither_valid  out  1  single-cycle strobe; high one cycle after each clk_en
seed_fault  out  1  single-cycle pulse when an all-zero seed or state is replaced by SEED

Behaviour:
- Reset, applied on a clk edge with rst=1: lfsr=SEED, dither=0, dither_valid=0, seed_fault=0. rst has priority over all other inputs.
- Priority when rst=0: seed_load first, then clk_en.
- seed_load=1:
  - lfsr<=seed. If seed==0, lfsr<=SEED and seed_fault<=1 for one cycle.
  - dither holds its value; dither_valid<=0; any clk_en in the same cycle is ignored.
- clk_en=1 (seed_load=0):
  - fb = XOR over i of (lfsr[i] & TAPS[i]).
  - lfsr <= {lfsr[LFSR_W-2:0], fb}.
  - dither <= f(current lfsr, mode, amp), computed from the pre-advance state.
  - dither_valid <= 1.
  - If lfsr==0 (zero-state protection), lfsr<=SEED, dither<=0 and seed_fault<=1 instead of the normal advance.
- clk_en=0: all state holds; dither_valid<=0; seed_fault<=0.
- Output function f, with s=lfsr:
  - Fields: UA = s[OUT_W-2:0] as signed (OUT_W-1) bits; UB = s[2*(OUT_W-1)-1:OUT_W-1] as signed (OUT_W-1) bits.
  - mode 00: 0. The LFSR still advances.
  - mode 01: s[LFSR_W-1] ? -1 : +1. amp is ignored.
  - mode 10: sign-extend UA to OUT_W bits, then >>> amp.
  - mode 11: UA + UB computed in OUT_W bits, which cannot overflow; then >>> amp.
- Latency: one clk from the clk_en edge to a valid dither. mode and amp are sampled on each clk_en edge, so changes apply to the next sample with no glitch.
- Period: with primitive TAPS, the sequence period is 2^LFSR_W - 1 enables, and the state never reaches 0 unless it is seeded with 0.

Test Plan:
- Setup for all cases: LFSR_W=4, TAPS=4'b1100, SEED=4'b0001, OUT_W=3. With these values the state sequence from 0001 is 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000, then back to 0001 (period 15).
- Reset, then mode=01, 15 enables -> dither = +1,+1,+1,-1,+1,+1,-1,-1,+1,-1,+1,-1,-1,-1,-1. Exactly 8×(-1) and 7×(+1). dither_valid high one cycle after each enable.
- seed_load with seed=0110, then mode=10 and amp=0 -> dither=-2 (3'b110). With mode=11 -> -1 (UA=-2, UB=+1). With mode=10 and amp=1 -> -1. With amp=5 (clamped to 2) and mode=10 -> -1.
- seed_load with seed=0 -> lfsr=0001, seed_fault pulses for exactly one cycle, dither unchanged. seed_load and clk_en asserted together -> seed loaded, no advance, dither_valid=0.
- clk_en gapped (1 of every 4 cycles) -> same sample sequence as the continuous case, all state held between enables. mode=00 -> dither=0 while the sequence continues; switching back to 01 resumes at the correct point.
- rst asserted mid-sequence together with clk_en -> next cycle lfsr=0001, dither=0, dither_valid=0. Default parameters, 2^24-1 enables -> state returns to SEED, never 0, seed_fault never asserted.

Source files
------------

// File: rtl/dither_gen_lfsr.sv
// Pseudo-random dither source for the DAC digital path.
// A Fibonacci LFSR with run-time seed load and zero-state protection feeds
// one of four output shapes: off, binary +/-1, uniform (RPDF) or triangular
// (TPDF). The registered sample can be attenuated by an arithmetic right
// shift, and a one-cycle valid strobe follows every sample-rate enable.
module dither_gen_lfsr #(
    parameter int                LFSR_W = 24,
    parameter logic [LFSR_W-1:0] TAPS   = 24'hE10000,
    parameter logic [LFSR_W-1:0] SEED   = 24'h000001,
    parameter int                OUT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [1:0]              mode,
    input  logic [2:0]              amp,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed,
    output logic signed [OUT_W-1:0] dither,
    output logic                    dither_valid,
    output logic                    seed_fault
);

    // Width of each uniform random field taken from the LFSR state.
    localparam int UW = OUT_W - 1;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BINARY = 2'b01,
        MODE_RPDF   = 2'b10,
        MODE_TPDF   = 2'b11
    } mode_e;

    logic [LFSR_W-1:0]       lfsr;
    logic                    fb;
    logic [2:0]              amp_sh;
    logic signed [OUT_W-1:0] ua_ext;
    logic signed [OUT_W-1:0] ub_ext;
    logic signed [OUT_W-1:0] sample;

    // Feedback bit: parity of the tapped state bits.
    assign fb = ^(lfsr & TAPS);

    // Two signed fields of the current state, sign-extended to the output width.
    assign ua_ext = {{(OUT_W-UW){lfsr[UW-1]}},   lfsr[UW-1:0]};
    assign ub_ext = {{(OUT_W-UW){lfsr[2*UW-1]}}, lfsr[2*UW-1:UW]};

    // Clamp the attenuation so a full-scale shift never exceeds the sign bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        amp_sh = amp;
        if (int'(amp) >= OUT_W) begin
            amp_sh = 3'(OUT_W - 1);
        end
    end

    // Shape the next dither sample from the pre-advance LFSR state.
    always_comb begin
        sample = '0;
        case (mode_e'(mode))
            MODE_OFF:    sample = '0;
            MODE_BINARY: sample = lfsr[LFSR_W-1] ? '1 : OUT_W'(1);
            MODE_RPDF:   sample = ua_ext >>> amp_sh;
            MODE_TPDF:   sample = (ua_ext + ub_ext) >>> amp_sh;
            default:     sample = '0;
        endcase
    end

    // LFSR advance, seed load, zero-state recovery and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr         <= SEED;
            dither       <= '0;
            dither_valid <= 1'b0;
            seed_fault   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the strobe
            // defaults below are safely overridden by later assignments in the
            // same block because only the last scheduled update takes effect.
            dither_valid <= 1'b0;
            seed_fault   <= 1'b0;
            if (seed_load) begin
                // A zero seed would lock the LFSR, so fall back to SEED.
                if (seed == '0) begin
                    lfsr       <= SEED;
                    seed_fault <= 1'b1;
                end else begin
                    lfsr <= seed;
                end
            end else if (clk_en) begin
                dither_valid <= 1'b1;
                if (lfsr == '0) begin
                    lfsr       <= SEED;
                    dither     <= '0;
                    seed_fault <= 1'b1;
                end else begin
                    lfsr   <= {lfsr[LFSR_W-2:0], fb};
                    dither <= sample;
                end
            end
        end
    end

endmodule

// File: tb/tb_dither_gen_lfsr.sv
// Self-checking bench for dither_gen_lfsr using a 4-bit LFSR and 3-bit output.
// The reference model tracks the LFSR as a position in the known maximal
// sequence and derives each sample arithmetically from the state value.
module tb_dither_gen_lfsr;

    localparam int LFSR_W = 4;
    localparam int OUT_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    clk_en = 1'b0;
    logic [1:0]              mode = 2'b00;
    logic [2:0]              amp = 3'd0;
    logic                    seed_load = 1'b0;
    logic [LFSR_W-1:0]       seed = '0;
    logic signed [OUT_W-1:0] dither;
    logic                    dither_valid;
    logic                    seed_fault;

    int checks   = 0;
    int failures = 0;

    // State sequence starting at 0001 for x^4+x^3+1.
    int seq_tab[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    // Binary-mode samples expected over one full period from reset.
    int exp_bin[15] = '{1, 1, 1, -1, 1, 1, -1, -1, 1, -1, 1, -1, -1, -1, -1};

    // Reference model state.
    int m_idx    = 0;
    int m_dither = 0;
    bit m_valid  = 1'b0;
    bit m_fault  = 1'b0;

    dither_gen_lfsr #(
        .LFSR_W(LFSR_W),
        .TAPS  (4'b1100),
        .SEED  (4'b0001),
        .OUT_W (OUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .mode        (mode),
        .amp         (amp),
        .seed_load   (seed_load),
        .seed        (seed),
        .dither      (dither),
        .dither_valid(dither_valid),
        .seed_fault  (seed_fault)
    );

    always #5 clk = ~clk;

    function automatic int seq_index(input int s);
        for (int i = 0; i < 15; i++) begin
            if (seq_tab[i] == s) return i;
        end
        return 0;
    endfunction

    function automatic int signed2(input int v);
        return (v >= 2) ? v - 4 : v;
    endfunction

    function automatic int floor_div(input int v, input int d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int model_sample(input int s, input int md, input int a);
        int sh;
        int ua;
        int ub;
        sh = (a >= OUT_W) ? OUT_W - 1 : a;
        ua = signed2(s % 4);
        ub = signed2((s / 4) % 4);
        case (md)
            0:       return 0;
            1:       return (s >= 8) ? -1 : 1;
            2:       return floor_div(ua, 1 << sh);
            default: return floor_div(ua + ub, 1 << sh);
        endcase
    endfunction

    // One clock: update the model from the inputs seen at the edge, then
    // step past the edge so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_idx = 0; m_dither = 0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (seed_load) begin
            m_valid = 1'b0;
            if (seed == 0) begin
                m_idx = 0; m_fault = 1'b1;
            end else begin
                m_idx = seq_index(int'(seed)); m_fault = 1'b0;
            end
        end else if (clk_en) begin
            m_dither = model_sample(seq_tab[m_idx], int'(mode), int'(amp));
            m_idx    = (m_idx + 1) % 15;
            m_valid  = 1'b1;
            m_fault  = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_fault = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b0; seed_load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int d;
        rst = 1'b1; clk_en = 1'b1; seed_load = 1'b1; seed = 4'b0000; mode = 2'b01;
        tick();
        rst = 1'b0; clk_en = 1'b0; seed_load = 1'b0;
        d = dither;
        checks++;
        if (d !== 0 || dither_valid !== 1'b0 || seed_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: dither=%0d valid=%b fault=%b, required 0/0/0",
                     d, dither_valid, seed_fault);
        end
    endtask

    task automatic test_binary_sequence();
        int d;
        int neg;
        do_reset();
        mode = 2'b01; amp = 3'($urandom_range(0, 7));
        for (int p = 0; p < 2; p++) begin
            neg = 0;
            for (int i = 0; i < 15; i++) begin
                clk_en = 1'b1;
                tick();
                d = dither;
                if (d == -1) neg++;
                checks++;
                if (d !== exp_bin[i] || dither_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL binary_seq[%0d/%0d]: dither=%0d valid=%b, required %0d/1",
                             p, i, d, dither_valid, exp_bin[i]);
                end
            end
            checks++;
            if (neg != 8) begin
                failures++;
                $display("FAIL binary_balance[%0d]: negatives=%0d, required 8", p, neg);
            end
        end
        clk_en = 1'b0;
        tick();
        checks++;
        if (dither_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_drop: valid=%b, required 0", dither_valid);
        end
    endtask

    task automatic test_output_modes();
        int md_t[7]  = '{2, 3, 2, 2, 3, 1, 2};
        int amp_t[7] = '{0, 0, 1, 5, 1, 3, 7};
        int exp_t[7] = '{-2, -1, -1, -1, -1, 1, -1};
        int d;
        for (int k = 0; k < 7; k++) begin
            seed_load = 1'b1; seed = 4'b0110; clk_en = 1'b0;
            tick();
            seed_load = 1'b0; clk_en = 1'b1;
            mode = 2'(md_t[k]); amp = 3'(amp_t[k]);
            tick();
            clk_en = 1'b0;
            d = dither;
            checks++;
            if (d !== exp_t[k] || dither_valid !== 1'b1) begin
                failures++;
                $display("FAIL mode_case[%0d] mode=%0d amp=%0d: dither=%0d valid=%b, required %0d/1",
                         k, md_t[k], amp_t[k], d, dither_valid, exp_t[k]);
            end
        end
    endtask

    task automatic test_seed_zero();
        int d;
        do_reset();
        mode = 2'b10; amp = 3'd0; clk_en = 1'b1;
        tick();
        clk_en = 1'b0; seed_load = 1'b1; seed = 4'b0000;
        tick();
        seed_load = 1'b0;
        d = dither;
        checks++;
        if (seed_fault !== 1'b1 || dither_valid !== 1'b0 || d !== 1) begin
            failures++;
            $display("FAIL seed_zero_load: fault=%b valid=%b dither=%0d, required 1/0/1",
                     seed_fault, dither_valid, d);
        end
        tick();
        d = dither;
        checks++;
        if (seed_fault !== 1'b0 || d !== 1) begin
            failures++;
            $display("FAIL seed_fault_pulse: fault=%b dither=%0d, required 0/1", seed_fault, d);
        end
        // 0001 restored: UA=+1, then the next state 0010 would give -2.
        clk_en = 1'b1;
        tick();
        d = dither;
        checks++;
        if (d !== 1 || dither_valid !== 1'b1) begin
            failures++;
            $display("FAIL seed_fallback_state: dither=%0d valid=%b, required 1/1", d, dither_valid);
        end
        // Load and enable together: load wins, nothing advances.
        seed_load = 1'b1; seed = 4'b1001;
        tick();
        seed_load = 1'b0;
        d = dither;
        checks++;
        if (d !== 1 || dither_valid !== 1'b0 || seed_fault !== 1'b0) begin
            failures++;
            $display("FAIL load_with_enable: dither=%0d valid=%b fault=%b, required 1/0/0",
                     d, dither_valid, seed_fault);
        end
        mode = 2'b01;
        tick();
        d = dither;
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL load_first_sample: dither=%0d, required -1", d);
        end
        mode = 2'b10;
        tick();
        clk_en = 1'b0;
        d = dither;
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL load_second_sample: dither=%0d, required -1", d);
        end
    endtask

    task automatic test_gapped();
        int d;
        do_reset();
        mode = 2'b01; amp = 3'd0;
        for (int i = 0; i < 15; i++) begin
            clk_en = 1'b1;
            tick();
            clk_en = 1'b0;
            d = dither;
            checks++;
            if (d !== exp_bin[i] || dither_valid !== 1'b1) begin
                failures++;
                $display("FAIL gapped_sample[%0d]: dither=%0d valid=%b, required %0d/1",
                         i, d, dither_valid, exp_bin[i]);
            end
            for (int g = 0; g < 3; g++) begin
                tick();
                d = dither;
                checks++;
                if (d !== exp_bin[i] || dither_valid !== 1'b0 || seed_fault !== 1'b0) begin
                    failures++;
                    $display("FAIL gapped_hold[%0d.%0d]: dither=%0d valid=%b fault=%b, required %0d/0/0",
                             i, g, d, dither_valid, seed_fault, exp_bin[i]);
                end
            end
        end
    endtask

    task automatic test_mode_off();
        int d;
        do_reset();
        clk_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            mode = (i >= 3 && i < 7) ? 2'b00 : 2'b01;
            tick();
            d = dither;
            checks++;
            if (d !== ((mode == 2'b00) ? 0 : exp_bin[i])) begin
                failures++;
                $display("FAIL mode_off_seq[%0d]: dither=%0d, required %0d",
                         i, d, (mode == 2'b00) ? 0 : exp_bin[i]);
            end
        end
        clk_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int d;
        do_reset();
        mode = 2'b01; clk_en = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d = dither;
        checks++;
        if (d !== 0 || dither_valid !== 1'b0 || seed_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: dither=%0d valid=%b fault=%b, required 0/0/0",
                     d, dither_valid, seed_fault);
        end
        mode = 2'b10; amp = 3'd0;
        tick();
        clk_en = 1'b0;
        d = dither;
        checks++;
        if (d !== 1 || dither_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_restart: dither=%0d valid=%b, required 1/1", d, dither_valid);
        end
    endtask

    task automatic test_random();
        int d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            seed_load = ($urandom_range(0, 99) < 6);
            seed      = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            clk_en    = ($urandom_range(0, 99) < 60);
            mode      = 2'($urandom);
            amp       = 3'($urandom);
            tick();
            d = dither;
            checks++;
            if (d !== m_dither || dither_valid !== m_valid || seed_fault !== m_fault) begin
                failures++;
                $display("FAIL random[%0d]: dither=%0d valid=%b fault=%b, required %0d/%b/%b",
                         i, d, dither_valid, seed_fault, m_dither, m_valid, m_fault);
            end
        end
        rst = 1'b0; seed_load = 1'b0; clk_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_binary_sequence();
        test_output_modes();
        test_seed_zero();
        test_gapped();
        test_mode_off();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
